// File: rtl/riscv_defs.sv
// Shared RV32I decode definitions: opcodes, ALU op codes, branch funct3, ctrl bits, issue payload.
package riscv_defs;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CTRL_W     = 4;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [6:0] OPCODE_ALUR   = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_OP_ADD     = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB     = 4'b1000;
  localparam logic [3:0] ALU_OP_SLL     = 4'b0001;
  localparam logic [3:0] ALU_OP_SLT     = 4'b0010;
  localparam logic [3:0] ALU_OP_SLTU    = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR     = 4'b0100;
  localparam logic [3:0] ALU_OP_SRL     = 4'b0101;
  localparam logic [3:0] ALU_OP_SRA     = 4'b1101;
  localparam logic [3:0] ALU_OP_OR      = 4'b0110;
  localparam logic [3:0] ALU_OP_AND     = 4'b0111;
  localparam logic [3:0] ALU_OP_EQ      = 4'b1001;
  localparam logic [3:0] ALU_OP_NEQ     = 4'b1010;
  localparam logic [3:0] ALU_OP_GE      = 4'b1100;
  localparam logic [3:0] ALU_OP_GEU     = 4'b1011;
  localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1111;

  localparam logic [2:0] BR_F3_BEQ  = 3'b000;
  localparam logic [2:0] BR_F3_BNE  = 3'b001;
  localparam logic [2:0] BR_F3_BLT  = 3'b100;
  localparam logic [2:0] BR_F3_BGE  = 3'b101;
  localparam logic [2:0] BR_F3_BLTU = 3'b110;
  localparam logic [2:0] BR_F3_BGEU = 3'b111;

  localparam int unsigned CTRL_BRANCH = 3;
  localparam int unsigned CTRL_JUMP   = 2;
  localparam int unsigned CTRL_LOAD   = 1;
  localparam int unsigned CTRL_STORE  = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_data1;
    logic [DATA_W-1:0]     alu_data2;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_we;
    logic [DATA_W-1:0]     store_data;
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     target;
    logic                  illegal;
  } issue_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Sign-extended RV32I immediates (I/S/B/U/J) from the upper instruction bits.
module riscv_imm_gen
  import riscv_defs::*;
(
  input  logic [31:7]       instr_i,
  output logic [DATA_W-1:0] imm_i_o,
  output logic [DATA_W-1:0] imm_s_o,
  output logic [DATA_W-1:0] imm_b_o,
  output logic [DATA_W-1:0] imm_u_o,
  output logic [DATA_W-1:0] imm_j_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'b0};
  assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

endmodule

// File: rtl/riscv_id_stage.sv
// RV32I decode/issue stage: decodes into an ALU bundle and issues it through a
// registered slot backed by a one-entry skid, so ready_o is a plain flop.
module riscv_id_stage
  import riscv_defs::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          RESET_PC_NOP = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  output logic [3:0]      alu_op_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [3:0]      ctrl_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [DATA_W-1:0] jalr_sum;

  issue_t      dec;
  logic        writes_rd, is_nop, is_bad, dec_keep;
  logic        accept, deq, push;
  skid_state_e state_q, state_d;
  issue_t      main_q, main_d, skid_q, skid_d;

  assign opcode     = instr_i[6:0];
  assign rd         = instr_i[11:7];
  assign funct3     = instr_i[14:12];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign jalr_sum   = rs1_data_i + imm_i;

  riscv_imm_gen u_imm_gen (
    .instr_i (instr_i[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  // Decode the offered instruction into an issue bundle
  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_OP_ADD;
    dec.rd_addr = rd;
    writes_rd   = 1'b0;
    is_nop      = 1'b0;
    is_bad      = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        dec.alu_data2 = imm_u;
        writes_rd     = 1'b1;
      end
      OPCODE_AUIPC: begin
        dec.alu_data1 = pc_i;
        dec.alu_data2 = imm_u;
        writes_rd     = 1'b1;
      end
      OPCODE_JAL: begin
        dec.alu_data1       = pc_i;
        dec.alu_data2       = 32'd4;
        dec.target          = pc_i + imm_j;
        dec.ctrl[CTRL_JUMP] = 1'b1;
        writes_rd           = 1'b1;
      end
      OPCODE_JALR: begin
        dec.alu_data1       = pc_i;
        dec.alu_data2       = 32'd4;
        dec.target          = jalr_sum & ~32'd1;
        dec.ctrl[CTRL_JUMP] = 1'b1;
        writes_rd           = 1'b1;
      end
      OPCODE_BRANCH: begin
        dec.alu_data1         = rs1_data_i;
        dec.alu_data2         = rs2_data_i;
        dec.target            = pc_i + imm_b;
        dec.ctrl[CTRL_BRANCH] = 1'b1;
        case (funct3)
          BR_F3_BEQ:  dec.alu_op = ALU_OP_EQ;
          BR_F3_BNE:  dec.alu_op = ALU_OP_NEQ;
          BR_F3_BLT:  dec.alu_op = ALU_OP_SLT;
          BR_F3_BGE:  dec.alu_op = ALU_OP_GE;
          BR_F3_BLTU: dec.alu_op = ALU_OP_SLTU;
          BR_F3_BGEU: dec.alu_op = ALU_OP_GEU;
          default:    is_bad     = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        dec.alu_data1       = rs1_data_i;
        dec.alu_data2       = imm_i;
        dec.ctrl[CTRL_LOAD] = 1'b1;
        writes_rd           = 1'b1;
      end
      OPCODE_STORE: begin
        dec.alu_data1        = rs1_data_i;
        dec.alu_data2        = imm_s;
        dec.store_data       = rs2_data_i;
        dec.ctrl[CTRL_STORE] = 1'b1;
      end
      OPCODE_ALUI: begin
        dec.alu_data1 = rs1_data_i;
        dec.alu_data2 = imm_i;
        dec.alu_op    = {instr_i[30] & (funct3 == 3'b101), funct3};
        writes_rd     = 1'b1;
      end
      OPCODE_ALUR: begin
        dec.alu_data1 = rs1_data_i;
        dec.alu_data2 = rs2_data_i;
        dec.alu_op    = {instr_i[30], funct3};
        writes_rd     = 1'b1;
      end
      OPCODE_FENCE, OPCODE_SYSTEM: is_nop = 1'b1;
      default: is_bad = 1'b1;
    endcase
    // Undecodable encodings issue as a flagged bubble with no operands
    if (is_bad) begin
      dec         = '0;
      dec.rd_addr = rd;
      dec.alu_op  = ALU_OP_ILLEGAL;
      dec.illegal = 1'b1;
    end
    dec.rd_we = writes_rd & (rd != 5'd0);
  end

  // NOP-class instructions are still consumed from fetch when not kept
  assign dec_keep = RESET_PC_NOP | ~(is_nop | is_bad);
  assign accept   = valid_i & ready_o;
  assign deq      = valid_o & ready_i;
  assign push     = accept & dec_keep;

  // Skid FSM next state and slot contents; flush overrides everything
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = dec;
          end
        end
        ST_ONE: begin
          if (push && deq) begin
            main_d = dec;
          end else if (push) begin
            state_d = ST_FULL;
            skid_d  = dec;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deq) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, slot and handshake registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_o <= (state_d != ST_EMPTY);
      ready_o <= (state_d != ST_FULL);
    end
  end

  assign alu_data1_o  = main_q.alu_data1;
  assign alu_data2_o  = main_q.alu_data2;
  assign alu_op_o     = main_q.alu_op;
  assign rd_addr_o    = main_q.rd_addr;
  assign rd_we_o      = main_q.rd_we;
  assign store_data_o = main_q.store_data;
  assign ctrl_o       = main_q.ctrl;
  assign target_o     = main_q.target;
  assign illegal_o    = main_q.illegal;

endmodule

// File: tb/tb_riscv_id_stage.sv
// Bench for riscv_id_stage: directed decode vectors, handshake/flush/reset scenarios
// and a randomized stream checked against a queue-based reference model.
module tb_riscv_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] alu_data1_o, alu_data2_o, store_data_o, target_o;
  logic [3:0]  alu_op_o, ctrl_o;
  logic        rd_we_o, illegal_o;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] sd;
    logic [3:0]  ctrl;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins, pc, r1, r2, d1, d2, tgt;
    logic [3:0]  op;
    logic        we, ill;
  } dir_t;

  always #5 clk_i = ~clk_i;

  assign rs1_data_i = regs[rs1_addr_o];
  assign rs2_data_i = regs[rs2_addr_o];

  riscv_id_stage #(.XLEN(32), .RESET_PC_NOP(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .alu_op_o(alu_op_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .store_data_o(store_data_o), .ctrl_o(ctrl_o),
    .target_o(target_o), .illegal_o(illegal_o)
  );

  // Reference decode: straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] ii, is, ib, iu, ij, bt;
    logic [2:0]  f3;
    logic        wr;
    int          idx;
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu = ins & 32'hFFFF_F000;
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    f3 = ins[14:12];
    bt = 32'hB3C2_FFA9;  // branch op per funct3, nibble 0 = funct3 000
    e = '0;
    e.rd = ins[11:7];
    wr = 1'b0;
    case (ins[6:0])
      7'h37: begin e.d2 = iu; wr = 1'b1; end
      7'h17: begin e.d1 = pc; e.d2 = iu; wr = 1'b1; end
      7'h6F: begin e.d1 = pc; e.d2 = 4; e.tgt = pc + ij; e.ctrl = 4'b0100; wr = 1'b1; end
      7'h67: begin e.d1 = pc; e.d2 = 4; e.tgt = (a + ii) & 32'hFFFF_FFFE; e.ctrl = 4'b0100; wr = 1'b1; end
      7'h63: begin
        idx = int'(f3) * 4;
        e.op = bt[idx +: 4];
        if (e.op == 4'hF) e.ill = 1'b1;
        else begin e.d1 = a; e.d2 = b; e.tgt = pc + ib; e.ctrl = 4'b1000; end
      end
      7'h03: begin e.d1 = a; e.d2 = ii; e.ctrl = 4'b0010; wr = 1'b1; end
      7'h23: begin e.d1 = a; e.d2 = is; e.sd = b; e.ctrl = 4'b0001; end
      7'h13: begin e.d1 = a; e.d2 = ii; e.op = {(f3 == 3'd5) & ins[30], f3}; wr = 1'b1; end
      7'h33: begin e.d1 = a; e.d2 = b; e.op = {ins[30], f3}; wr = 1'b1; end
      7'h0F, 7'h73: ;
      default: begin e.op = 4'hF; e.ill = 1'b1; end
    endcase
    e.we = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.d1 = alu_data1_o; o.d2 = alu_data2_o; o.op = alu_op_o; o.rd = rd_addr_o;
    o.we = rd_we_o; o.sd = store_data_o; o.ctrl = ctrl_o; o.tgt = target_o;
    o.ill = illegal_o;
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8: opc = 7'h33;  9: opc = 7'h0F; 10: opc = 7'h73;
      default: opc = 7'h5B;
    endcase
    return {r[31:7], opc};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    instr_i = '0; pc_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (observe() !== exp_t'(0)) begin errors++; $display("FAIL reset_data got=%h exp=0", observe()); end
    rst_ni = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL idle_after_reset got v=%b r=%b exp v=0 r=1", valid_o, ready_o); end
  endtask

  task automatic test_directed();
    dir_t vec [8];
    exp_t e, o;
    vec[0] = '{32'hFFF10093, 32'h0,   32'd5,         32'd0, 32'd5,         32'hFFFFFFFF, 32'h0,   4'h0, 1'b1, 1'b0};
    vec[1] = '{32'h402081B3, 32'h0,   32'd10,        32'd3, 32'd10,        32'd3,        32'h0,   4'h8, 1'b1, 1'b0};
    vec[2] = '{32'h40335293, 32'h0,   32'h80000000,  32'd0, 32'h80000000,  32'h403,      32'h0,   4'hD, 1'b1, 1'b0};
    vec[3] = '{32'h00335293, 32'h0,   32'h80000000,  32'd0, 32'h80000000,  32'h3,        32'h0,   4'h5, 1'b1, 1'b0};
    vec[4] = '{32'h0020D463, 32'h100, 32'd1,         32'd2, 32'd1,         32'd2,        32'h108, 4'hC, 1'b0, 1'b0};
    vec[5] = '{32'h0020E463, 32'h100, 32'd1,         32'd2, 32'd1,         32'd2,        32'h108, 4'h3, 1'b0, 1'b0};
    vec[6] = '{32'h0000007F, 32'h40,  32'd0,         32'd0, 32'd0,         32'd0,        32'h0,   4'hF, 1'b0, 1'b1};
    vec[7] = '{32'h0020A463, 32'h100, 32'd1,         32'd2, 32'd0,         32'd0,        32'h0,   4'hF, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      if (vec[i].ins[19:15] != 5'd0) regs[vec[i].ins[19:15]] = vec[i].r1;
      if (vec[i].ins[24:20] != 5'd0) regs[vec[i].ins[24:20]] = vec[i].r2;
      instr_i = vec[i].ins; pc_i = vec[i].pc;
      e = model(vec[i].ins, vec[i].pc, vec[i].r1, vec[i].r2);
      valid_i = 1'b1; ready_i = 1'b1;
      tick();
      valid_i = 1'b0;
      o = observe();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got=%b exp=1", i, valid_o); end
      checks++;
      if ({o.op, o.d1, o.d2, o.tgt, o.we, o.ill} !==
          {vec[i].op, vec[i].d1, vec[i].d2, vec[i].tgt, vec[i].we, vec[i].ill}) begin
        errors++;
        $display("FAIL dir%0d_fields got op=%h d1=%h d2=%h tgt=%h we=%b ill=%b exp op=%h d1=%h d2=%h tgt=%h we=%b ill=%b",
                 i, o.op, o.d1, o.d2, o.tgt, o.we, o.ill,
                 vec[i].op, vec[i].d1, vec[i].d2, vec[i].tgt, vec[i].we, vec[i].ill);
      end
      checks++; if (o !== e) begin errors++; $display("FAIL dir%0d_bundle got=%h exp=%h", i, o, e); end
    end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL dir_drain_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ia, ib, ic;
    exp_t ea, eb;
    ia = 32'h00100093; ib = 32'h00200113; ic = 32'h00300193;
    pc_i = 32'h0;
    ea = model(ia, 32'h0, regs[0], regs[1]);
    eb = model(ib, 32'h0, regs[0], regs[2]);
    ready_i = 1'b0; valid_i = 1'b1; instr_i = ia;
    tick();
    checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL bp_c1_hs got v=%b r=%b exp v=1 r=1", valid_o, ready_o); end
    checks++; if (observe() !== ea) begin errors++; $display("FAIL bp_c1_data got=%h exp=%h", observe(), ea); end
    instr_i = ib;
    tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_c2_ready got=%b exp=0", ready_o); end
    checks++; if (observe() !== ea) begin errors++; $display("FAIL bp_c2_frozen got=%h exp=%h", observe(), ea); end
    instr_i = ic;
    tick();
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_c3_hs got v=%b r=%b exp v=1 r=0", valid_o, ready_o); end
    checks++; if (observe() !== ea) begin errors++; $display("FAIL bp_c3_frozen got=%h exp=%h", observe(), ea); end
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL bp_drain1_hs got v=%b r=%b exp v=1 r=1", valid_o, ready_o); end
    checks++; if (observe() !== eb) begin errors++; $display("FAIL bp_drain1_data got=%h exp=%h", observe(), eb); end
    tick();
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL bp_drain2_hs got v=%b r=%b exp v=0 r=1", valid_o, ready_o); end
  endtask

  task automatic test_flush();
    exp_t ec;
    pc_i = 32'h200;
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00100093;
    tick();
    instr_i = 32'h00200113;
    tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_full_ready got=%b exp=0", ready_o); end
    flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; instr_i = 32'h00300193;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_full_hs got v=%b r=%b exp v=0 r=1", valid_o, ready_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale%0d got=%b exp=0", i, valid_o); end
    end
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00100093;
    tick();
    flush_i = 1'b1; instr_i = 32'h00200113;
    tick();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_one_hs got v=%b r=%b exp v=0 r=1", valid_o, ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_one_stale got=%b exp=0", valid_o); end
    instr_i = 32'h00500293;
    ec = model(32'h00500293, 32'h200, regs[0], regs[5]);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || observe() !== ec) begin errors++; $display("FAIL flush_recover got v=%b d=%h exp v=1 d=%h", valid_o, observe(), ec); end
    tick();
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00100093;
    tick();
    instr_i = 32'h00200113;
    tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b exp=0", ready_o); end
    #1;
    rst_ni = 1'b0; valid_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_async got v=%b r=%b exp v=0 r=1", valid_o, ready_o); end
    checks++; if (observe() !== exp_t'(0)) begin errors++; $display("FAIL rstmid_data got=%h exp=0", observe()); end
    tick();
    rst_ni = 1'b1; ready_i = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", valid_o); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   sz;
    q.delete();
    for (int cyc = 0; cyc < 3004; cyc++) begin
      checks++; if (valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_o, q.size() != 0); end
      checks++; if (ready_o !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready_o, q.size() < 2); end
      if (q.size() != 0 && valid_o === 1'b1) begin
        checks++; if (observe() !== q[0]) begin errors++; $display("FAIL rnd_bundle cyc=%0d got=%h exp=%h", cyc, observe(), q[0]); end
      end
      regs[$urandom_range(1, 31)] = $urandom();
      instr_i = rand_instr();
      pc_i    = $urandom();
      if (cyc < 3000) begin
        valid_i = ($urandom_range(0, 99) < 60);
        ready_i = ($urandom_range(0, 99) < 50);
        flush_i = ($urandom_range(0, 99) < 3);
      end else begin
        valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
      end
      e  = model(instr_i, pc_i, regs[instr_i[19:15]], regs[instr_i[24:20]]);
      sz = q.size();
      if (flush_i) q.delete();
      else begin
        if (sz != 0 && ready_i) void'(q.pop_front());
        if (valid_i && sz < 2) q.push_back(e);
      end
      tick();
    end
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rnd_final got v=%b q=%0d exp v=0 q=0", valid_o, q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom();
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
